ahb_sram_slave: RTL

AHB slave with a local word-organised SRAM, placed directly downstream of the AXI-AHB bridge and driven by its AHB master port. Accepts single AHB transfers with a pipelined address/data phase and programmable wait states. Out-of-range accesses return the two-cycle AHB ERROR response. Byte-strobed writes are supported.

---
 rtl/ahb_sram_slave_if.sv | 23 ++
 rtl/ahb_sram_slave.sv | 109 ++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite style bus bundle between the upstream bridge (master) and the SRAM slave.
// The clock and reset stay plain ports on the slave; everything here is beat-qualified.
interface ahb_sram_slave_if;
   logic        h_clk_en;
   logic [31:0] h_addr;
   logic [1:0]  h_trans;
   logic        h_write;
   logic [31:0] h_wdata;
   logic [3:0]  h_wstrb;
   logic [31:0] h_rdata;
   logic        h_ready;
   logic        h_resp;

   modport master (
      output h_clk_en, h_addr, h_trans, h_write, h_wdata, h_wstrb,
      input  h_rdata, h_ready, h_resp
   );

   modport slave (
      input  h_clk_en, h_addr, h_trans, h_write, h_wdata, h_wstrb,
      output h_rdata, h_ready, h_resp
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB slave backed by a word-organised SRAM: pipelined address/data phases,
// fixed wait states on OKAY transfers, two-beat ERROR for out-of-range addresses.
module ahb_sram_slave #(
   parameter int Depth      = 64,
   parameter int WaitStates = 0
) (
   input logic            a_clk,
   input logic            a_reset,
   ahb_sram_slave_if.slave bus
);
   localparam int AW = $clog2(Depth);
   localparam logic [3:0]  WAIT_INIT  = 4'(WaitStates);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * Depth);

   typedef enum logic [2:0] {
      ST_NONE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t        state_reg, state_next;
   logic [3:0]    wcnt_reg, wcnt_next;
   logic [AW-1:0] ph_addr_reg;
   logic          ph_write_reg;
   logic          ready_reg;
   logic          resp_reg;
   logic [31:0]   mem [Depth];

   logic          accept;
   logic          addr_err;
   logic [31:0]   wmask;
   logic          unused_bits;

   assign unused_bits = ^{bus.h_addr[1:0], bus.h_trans[0]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wmask
         assign wmask[gi*8 +: 8] = {8{bus.h_wstrb[gi]}};
      end
   endgenerate

   // ready_reg is 1 exactly in NONE/LAST/ERR2, the states that can take a new address
   assign accept   = ready_reg && bus.h_trans[1];
   assign addr_err = (bus.h_addr >= ADDR_LIMIT);

   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      case (state_reg)
         ST_WAIT: begin
            wcnt_next = wcnt_reg - 4'd1;
            if (wcnt_reg == 4'd1) begin
               state_next = ST_LAST;
            end
         end
         ST_ERR1: begin
            state_next = ST_ERR2;
         end
         default: begin
            state_next = ST_NONE;
            if (accept) begin
               wcnt_next = WAIT_INIT;
               if (addr_err) begin
                  state_next = ST_ERR1;
               end else if (WaitStates > 0) begin
                  state_next = ST_WAIT;
               end else begin
                  state_next = ST_LAST;
               end
            end
         end
      endcase
   end

   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         state_reg    <= ST_NONE;
         wcnt_reg     <= 4'd0;
         ready_reg    <= 1'b1;
         resp_reg     <= 1'b0;
         ph_addr_reg  <= '0;
         ph_write_reg <= 1'b0;
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (bus.h_clk_en) begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
         ready_reg <= !((state_next == ST_WAIT) || (state_next == ST_ERR1));
         resp_reg  <= (state_next == ST_ERR1) || (state_next == ST_ERR2);
         if (accept) begin
            ph_addr_reg  <= bus.h_addr[AW+1:2];
            ph_write_reg <= bus.h_write;
         end
         // write data is only valid in the final data-phase beat
         if ((state_reg == ST_LAST) && ph_write_reg) begin
            mem[ph_addr_reg] <= (mem[ph_addr_reg] & ~wmask) | (bus.h_wdata & wmask);
         end
      end
   end

   assign bus.h_ready = ready_reg;
   assign bus.h_resp  = resp_reg;
   assign bus.h_rdata = ((state_reg == ST_LAST) && !ph_write_reg) ? mem[ph_addr_reg] : 32'd0;

endmodule
